// File: rtl/id_stage.sv
// Decode stage of the LA32R 5-stage pipeline: latches one {pc, inst} packet,
// reads the register file, resolves branches and interlocks on RAW hazards.
module id_stage #(
   parameter int FS_TO_DS_BUS_WD = 64,
   parameter int BR_BUS_WD       = 33,
   parameter int DS_TO_ES_BUS_WD = 148,
   parameter int WS_TO_RF_BUS_WD = 38
) (
   input  logic                       clk,
   input  logic                       reset,
   // fetch side
   input  logic                       fs_to_ds_valid,
   input  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
   output logic                       ds_allow_in,
   output logic [BR_BUS_WD-1:0]       brbus,
   // execute side
   input  logic                       es_allow_in,
   output logic                       ds_to_es_valid,
   output logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
   // writeback port and in-flight destinations
   input  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
   input  logic [5:0]                 es_to_ds_dest,
   input  logic [5:0]                 ms_to_ds_dest,
   input  logic [5:0]                 ws_to_ds_dest
);

   logic        ds_valid;
   logic [31:0] ds_pc;
   logic [31:0] ds_inst;
   logic        ds_ready_go;
   logic        hazard;
   logic        br_taken;
   logic        br_cond;
   logic [31:0] br_target;

   // instruction fields
   logic [4:0]  rd;
   logic [4:0]  rj;
   logic [4:0]  rk;
   logic [16:0] op_31_15;
   logic [9:0]  op_31_22;
   logic [5:0]  op_31_26;
   logic [6:0]  op_31_25;

   // decoded instructions
   logic inst_add_w;
   logic inst_sub_w;
   logic inst_slt;
   logic inst_sltu;
   logic inst_nor;
   logic inst_and;
   logic inst_or;
   logic inst_xor;
   logic inst_slli_w;
   logic inst_srli_w;
   logic inst_srai_w;
   logic inst_addi_w;
   logic inst_ld_w;
   logic inst_st_w;
   logic inst_jirl;
   logic inst_b;
   logic inst_bl;
   logic inst_beq;
   logic inst_bne;
   logic inst_lu12i_w;

   logic inst_3r;
   logic inst_shift_imm;
   logic inst_valid_op;

   // immediates
   logic [31:0] imm_si12;
   logic [31:0] imm_ui5;
   logic [31:0] imm_si20;
   logic [31:0] imm_offs16;
   logic [31:0] imm_offs26;

   // control bundle
   logic [11:0] alu_op;
   logic        res_from_mem;
   logic        mem_we;
   logic        gr_we;
   logic [4:0]  dest;
   logic [31:0] alu_src1;
   logic [31:0] alu_src2;
   logic [31:0] rkd_value;

   // register file
   logic [31:0] rf [32];
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  rf_raddr2;
   logic        src_reg_is_rd;
   logic [31:0] rj_value;
   logic [31:0] rf_rdata2;

   // hazard terms
   logic uses_rj;
   logic uses_rk;
   logic uses_rd;
   logic rj_hit;
   logic rk_hit;
   logic rd_hit;

   // A taken branch leaving decode also kills the sequential packet being handed over.
   always_ff @(posedge clk) begin
      if (reset) begin
         ds_valid <= 1'b0;
      end else if (ds_allow_in) begin
         ds_valid <= fs_to_ds_valid & ~br_taken;
      end
   end

   always_ff @(posedge clk) begin
      if (ds_allow_in) begin
         {ds_pc, ds_inst} <= fs_to_ds_bus;
      end
   end

   assign ds_ready_go    = ~hazard;
   assign ds_allow_in    = ~ds_valid | (ds_ready_go & es_allow_in);
   assign ds_to_es_valid = ds_valid & ds_ready_go;

   assign rd       = ds_inst[4:0];
   assign rj       = ds_inst[9:5];
   assign rk       = ds_inst[14:10];
   assign op_31_15 = ds_inst[31:15];
   assign op_31_22 = ds_inst[31:22];
   assign op_31_26 = ds_inst[31:26];
   assign op_31_25 = ds_inst[31:25];

   assign inst_add_w   = (op_31_15 == 17'h00020);
   assign inst_sub_w   = (op_31_15 == 17'h00022);
   assign inst_slt     = (op_31_15 == 17'h00024);
   assign inst_sltu    = (op_31_15 == 17'h00025);
   assign inst_nor     = (op_31_15 == 17'h00028);
   assign inst_and     = (op_31_15 == 17'h00029);
   assign inst_or      = (op_31_15 == 17'h0002a);
   assign inst_xor     = (op_31_15 == 17'h0002b);
   assign inst_slli_w  = (op_31_15 == 17'h00081);
   assign inst_srli_w  = (op_31_15 == 17'h00089);
   assign inst_srai_w  = (op_31_15 == 17'h00091);
   assign inst_addi_w  = (op_31_22 == 10'h00a);
   assign inst_ld_w    = (op_31_22 == 10'h0a2);
   assign inst_st_w    = (op_31_22 == 10'h0a6);
   assign inst_jirl    = (op_31_26 == 6'h13);
   assign inst_b       = (op_31_26 == 6'h14);
   assign inst_bl      = (op_31_26 == 6'h15);
   assign inst_beq     = (op_31_26 == 6'h16);
   assign inst_bne     = (op_31_26 == 6'h17);
   assign inst_lu12i_w = (op_31_25 == 7'h0a);

   assign inst_3r = inst_add_w | inst_sub_w | inst_slt | inst_sltu
                  | inst_nor | inst_and | inst_or | inst_xor;
   assign inst_shift_imm = inst_slli_w | inst_srli_w | inst_srai_w;
   assign inst_valid_op  = inst_3r | inst_shift_imm | inst_addi_w | inst_ld_w | inst_st_w
                         | inst_jirl | inst_b | inst_bl | inst_beq | inst_bne | inst_lu12i_w;

   assign imm_si12   = {{20{ds_inst[21]}}, ds_inst[21:10]};
   assign imm_ui5    = {27'b0, ds_inst[14:10]};
   assign imm_si20   = {ds_inst[24:5], 12'b0};
   assign imm_offs16 = {{14{ds_inst[25]}}, ds_inst[25:10], 2'b0};
   assign imm_offs26 = {{4{ds_inst[9]}}, ds_inst[9:0], ds_inst[25:10], 2'b0};

   assign alu_op[0]  = inst_add_w | inst_addi_w | inst_ld_w | inst_st_w | inst_bl | inst_jirl;
   assign alu_op[1]  = inst_sub_w;
   assign alu_op[2]  = inst_slt;
   assign alu_op[3]  = inst_sltu;
   assign alu_op[4]  = inst_and;
   assign alu_op[5]  = inst_nor;
   assign alu_op[6]  = inst_or;
   assign alu_op[7]  = inst_xor;
   assign alu_op[8]  = inst_slli_w;
   assign alu_op[9]  = inst_srli_w;
   assign alu_op[10] = inst_srai_w;
   assign alu_op[11] = inst_lu12i_w;

   assign res_from_mem = inst_ld_w;
   assign mem_we       = inst_st_w;
   assign gr_we        = inst_valid_op & ~inst_st_w & ~inst_b & ~inst_beq & ~inst_bne;
   assign dest         = ~gr_we ? 5'd0 : (inst_bl ? 5'd1 : rd);

   // Port 2 serves rd for ops that compare or store it, rk for everything else.
   assign {rf_we, rf_waddr, rf_wdata} = ws_to_rf_bus;
   assign src_reg_is_rd = inst_beq | inst_bne | inst_st_w;
   assign rf_raddr2     = src_reg_is_rd ? rd : rk;

   always_ff @(posedge clk) begin
      if (rf_we && (rf_waddr != 5'd0)) begin
         rf[rf_waddr] <= rf_wdata;
      end
   end

   assign rj_value  = (rj == 5'd0)        ? 32'd0 : rf[rj];
   assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'd0 : rf[rf_raddr2];
   assign rkd_value = rf_rdata2;

   always_comb begin
      alu_src1 = rj_value;
      alu_src2 = rf_rdata2;
      if (inst_bl | inst_jirl) begin
         alu_src1 = ds_pc;
         alu_src2 = 32'd4;
      end else if (inst_addi_w | inst_ld_w | inst_st_w) begin
         alu_src2 = imm_si12;
      end else if (inst_shift_imm) begin
         alu_src2 = imm_ui5;
      end else if (inst_lu12i_w) begin
         alu_src2 = imm_si20;
      end
   end

   always_comb begin
      br_target = ds_pc + imm_offs26;
      if (inst_beq | inst_bne) begin
         br_target = ds_pc + imm_offs16;
      end else if (inst_jirl) begin
         br_target = rj_value + imm_offs16;
      end
   end

   assign br_cond  = (inst_beq & (rj_value == rf_rdata2))
                   | (inst_bne & (rj_value != rf_rdata2))
                   | inst_b | inst_bl | inst_jirl;
   assign br_taken = ds_valid & ds_ready_go & es_allow_in & br_cond;
   assign brbus    = {br_taken, br_target};

   // A source only interlocks if the op actually reads it and it is not r0.
   function automatic logic dest_hit(input logic [5:0] d, input logic [4:0] r);
      return d[5] && (d[4:0] == r);
   endfunction

   assign uses_rj = inst_valid_op & ~inst_b & ~inst_bl & ~inst_lu12i_w;
   assign uses_rk = inst_3r;
   assign uses_rd = inst_beq | inst_bne | inst_st_w;

   assign rj_hit = (rj != 5'd0) && (dest_hit(es_to_ds_dest, rj)
                 || dest_hit(ms_to_ds_dest, rj) || dest_hit(ws_to_ds_dest, rj));
   assign rk_hit = (rk != 5'd0) && (dest_hit(es_to_ds_dest, rk)
                 || dest_hit(ms_to_ds_dest, rk) || dest_hit(ws_to_ds_dest, rk));
   assign rd_hit = (rd != 5'd0) && (dest_hit(es_to_ds_dest, rd)
                 || dest_hit(ms_to_ds_dest, rd) || dest_hit(ws_to_ds_dest, rd));

   assign hazard = (uses_rj & rj_hit) | (uses_rk & rk_hit) | (uses_rd & rd_hit);

   assign ds_to_es_bus = {alu_op, res_from_mem, mem_we, gr_we, dest,
                          alu_src1, alu_src2, rkd_value, ds_pc};

endmodule

// File: tb/tb_id_stage.sv
// Table-driven bench for id_stage: decode vectors, hazard cases, and
// hand-written sequences for branch drop, back-pressure, WB stall and reset.
module tb_id_stage;

   logic         clk;
   logic         reset;
   logic         fs_to_ds_valid;
   logic [63:0]  fs_to_ds_bus;
   logic         ds_allow_in;
   logic [32:0]  brbus;
   logic         es_allow_in;
   logic         ds_to_es_valid;
   logic [147:0] ds_to_es_bus;
   logic [37:0]  ws_to_rf_bus;
   logic [5:0]   es_to_ds_dest;
   logic [5:0]   ms_to_ds_dest;
   logic [5:0]   ws_to_ds_dest;

   int total = 0;
   int bad   = 0;

   id_stage dut (
      .clk            (clk),
      .reset          (reset),
      .fs_to_ds_valid (fs_to_ds_valid),
      .fs_to_ds_bus   (fs_to_ds_bus),
      .ds_allow_in    (ds_allow_in),
      .brbus          (brbus),
      .es_allow_in    (es_allow_in),
      .ds_to_es_valid (ds_to_es_valid),
      .ds_to_es_bus   (ds_to_es_bus),
      .ws_to_rf_bus   (ws_to_rf_bus),
      .es_to_ds_dest  (es_to_ds_dest),
      .ms_to_ds_dest  (ms_to_ds_dest),
      .ws_to_ds_dest  (ws_to_ds_dest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [11:0] f_alu_op;
   logic [7:0]  f_ctrl;
   logic [31:0] f_src1;
   logic [31:0] f_src2;
   logic [31:0] f_rkd;
   logic [31:0] f_pc;
   assign f_alu_op = ds_to_es_bus[147:136];
   assign f_ctrl   = ds_to_es_bus[135:128];
   assign f_src1   = ds_to_es_bus[127:96];
   assign f_src2   = ds_to_es_bus[95:64];
   assign f_rkd    = ds_to_es_bus[63:32];
   assign f_pc     = ds_to_es_bus[31:0];

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [11:0] alu_op;
      logic [7:0]  ctrl;
      logic        chk_src;
      logic [31:0] src1;
      logic [31:0] src2;
      logic        chk_rkd;
      logic [31:0] rkd;
      logic        br;
      logic [31:0] target;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] inst;
      logic [5:0]  es;
      logic [5:0]  ms;
      logic [5:0]  ws;
      logic        stall;
   } haz_t;

   vec_t vecs[$];
   haz_t hazs[$];

   function automatic logic [31:0] r3(input logic [16:0] op, input logic [4:0] rd,
                                      input logic [4:0] rj, input logic [4:0] rk);
      return {op, rk, rj, rd};
   endfunction

   function automatic logic [31:0] i12(input logic [9:0] op, input logic [4:0] rd,
                                       input logic [4:0] rj, input logic [11:0] imm);
      return {op, imm, rj, rd};
   endfunction

   function automatic logic [31:0] i16(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rj, input logic [15:0] offs);
      return {op, offs, rj, rd};
   endfunction

   function automatic logic [31:0] b26(input logic [5:0] op, input logic [25:0] offs);
      return {op, offs[15:0], offs[25:16]};
   endfunction

   function automatic logic [31:0] lu(input logic [4:0] rd, input logic [19:0] si20);
      return {7'h0a, si20, rd};
   endfunction

   function automatic void addVec(input string name, input logic [31:0] pc, input logic [31:0] inst,
                                  input logic [11:0] alu_op, input logic rfm, input logic mwe,
                                  input logic gwe, input logic [4:0] dest, input logic chk_src,
                                  input logic [31:0] src1, input logic [31:0] src2,
                                  input logic chk_rkd, input logic [31:0] rkd,
                                  input logic br, input logic [31:0] target);
      vec_t v;
      v.name = name;  v.pc = pc;  v.inst = inst;  v.alu_op = alu_op;
      v.ctrl = {rfm, mwe, gwe, dest};
      v.chk_src = chk_src;  v.src1 = src1;  v.src2 = src2;
      v.chk_rkd = chk_rkd;  v.rkd = rkd;  v.br = br;  v.target = target;
      vecs.push_back(v);
   endfunction

   function automatic void addHaz(input string name, input logic [31:0] inst, input logic [5:0] es,
                                  input logic [5:0] ms, input logic [5:0] ws, input logic stall);
      haz_t h;
      h.name = name;  h.inst = inst;  h.es = es;  h.ms = ms;  h.ws = ws;  h.stall = stall;
      hazs.push_back(h);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic fv, input logic [31:0] pc, input logic [31:0] inst);
      fs_to_ds_valid = fv;
      fs_to_ds_bus   = {pc, inst};
   endtask

   task automatic setDests(input logic [5:0] es, input logic [5:0] ms, input logic [5:0] ws);
      es_to_ds_dest = es;
      ms_to_ds_dest = ms;
      ws_to_ds_dest = ws;
   endtask

   task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
      ws_to_rf_bus = {1'b1, addr, data};
      cyc();
      ws_to_rf_bus = '0;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      es_allow_in = 1'b1;
      ws_to_rf_bus = '0;
      setDests(6'd0, 6'd0, 6'd0);
      applyStimulus(1'b1, 32'h1c000000, 32'h02bffca6);

      // reset held for three cycles with a valid packet offered
      for (int i = 0; i < 3; i++) begin
         cyc();
         checkOutput("reset.valid", {31'd0, ds_to_es_valid}, 32'd0);
         checkOutput("reset.br_taken", {31'd0, brbus[32]}, 32'd0);
         checkOutput("reset.allow_in", {31'd0, ds_allow_in}, 32'd1);
      end
      reset = 1'b0;
      applyStimulus(1'b0, 32'd0, 32'd0);

      writeReg(5'd1, 32'h00000010);
      writeReg(5'd2, 32'hfffffff0);
      writeReg(5'd5, 32'h12345678);
      writeReg(5'd7, 32'h12345678);
      writeReg(5'd0, 32'hdeadbeef);

      addVec("add",  32'h1c000100, r3(17'h20, 3, 1, 2),  12'h001, 0,0,1,3,  1, 32'h10, 32'hfffffff0, 0,0, 0,0);
      addVec("sub",  32'h1c000104, r3(17'h22, 4, 5, 1),  12'h002, 0,0,1,4,  1, 32'h12345678, 32'h10, 0,0, 0,0);
      addVec("slt",  32'h1c000108, r3(17'h24, 9, 2, 1),  12'h004, 0,0,1,9,  1, 32'hfffffff0, 32'h10, 0,0, 0,0);
      addVec("sltu", 32'h1c00010c, r3(17'h25, 10, 1, 2), 12'h008, 0,0,1,10, 1, 32'h10, 32'hfffffff0, 0,0, 0,0);
      addVec("nor",  32'h1c000110, r3(17'h28, 11, 1, 5), 12'h020, 0,0,1,11, 1, 32'h10, 32'h12345678, 0,0, 0,0);
      addVec("and",  32'h1c000114, r3(17'h29, 16, 5, 2), 12'h010, 0,0,1,16, 1, 32'h12345678, 32'hfffffff0, 0,0, 0,0);
      addVec("or",   32'h1c000118, r3(17'h2a, 17, 1, 5), 12'h040, 0,0,1,17, 1, 32'h10, 32'h12345678, 0,0, 0,0);
      addVec("xor",  32'h1c00011c, r3(17'h2b, 18, 2, 1), 12'h080, 0,0,1,18, 1, 32'hfffffff0, 32'h10, 0,0, 0,0);
      addVec("slli", 32'h1c000120, r3(17'h81, 12, 5, 4), 12'h100, 0,0,1,12, 1, 32'h12345678, 32'h4, 0,0, 0,0);
      addVec("srli", 32'h1c000124, r3(17'h89, 13, 2, 31),12'h200, 0,0,1,13, 1, 32'hfffffff0, 32'h1f, 0,0, 0,0);
      addVec("srai", 32'h1c000128, r3(17'h91, 19, 2, 1), 12'h400, 0,0,1,19, 1, 32'hfffffff0, 32'h1, 0,0, 0,0);
      addVec("addi_m1",  32'h1c00012c, 32'h02bffca6,          12'h001, 0,0,1,6,  1, 32'h12345678, 32'hffffffff, 0,0, 0,0);
      addVec("addi_max", 32'h1c000130, i12(10'h00a, 21, 1, 12'h7ff), 12'h001, 0,0,1,21, 1, 32'h10, 32'h000007ff, 0,0, 0,0);
      addVec("addi_min", 32'h1c000134, i12(10'h00a, 22, 1, 12'h800), 12'h001, 0,0,1,22, 1, 32'h10, 32'hfffff800, 0,0, 0,0);
      addVec("addi_r0",  32'h1c000138, i12(10'h00a, 0, 1, 12'h001),  12'h001, 0,0,1,0,  1, 32'h10, 32'h1, 0,0, 0,0);
      addVec("ld",   32'h1c00013c, i12(10'h0a2, 14, 2, 12'hffc), 12'h001, 1,0,1,14, 1, 32'hfffffff0, 32'hfffffffc, 0,0, 0,0);
      addVec("st",   32'h1c000140, i12(10'h0a6, 5, 1, 12'h008),  12'h001, 0,1,0,0,  1, 32'h10, 32'h8, 1, 32'h12345678, 0,0);
      addVec("lu12i",32'h1c000144, lu(15, 20'habce0),            12'h800, 0,0,1,15, 1, 32'h0, 32'habce0000, 0,0, 0,0);
      addVec("jirl", 32'h1c000180, i16(6'h13, 20, 1, 16'h0010),  12'h001, 0,0,1,20, 1, 32'h1c000180, 32'h4, 0,0, 1, 32'h00000050);
      addVec("b",    32'h1c000184, b26(6'h14, 26'h3ffffff),      12'h000, 0,0,0,0,  0, 0, 0, 0,0, 1, 32'h1c000180);
      addVec("bl",   32'h1c000000, 32'h54040000,                 12'h001, 0,0,1,1,  1, 32'h1c000000, 32'h4, 0,0, 1, 32'h1c000400);
      addVec("beq_t",  32'h1c000190, i16(6'h16, 7, 5, 16'hffff), 12'h000, 0,0,0,0, 0, 0, 0, 0,0, 1, 32'h1c00018c);
      addVec("bne_nt", 32'h1c000194, i16(6'h17, 7, 5, 16'h0020), 12'h000, 0,0,0,0, 0, 0, 0, 0,0, 0, 0);
      addVec("bne_t",  32'h1c000198, i16(6'h17, 2, 1, 16'h0020), 12'h000, 0,0,0,0, 0, 0, 0, 0,0, 1, 32'h1c000218);
      addVec("beq_nt", 32'h1c00019c, i16(6'h16, 2, 1, 16'h0004), 12'h000, 0,0,0,0, 0, 0, 0, 0,0, 0, 0);
      addVec("beq_far",32'h1c0001a0, i16(6'h16, 0, 0, 16'h7fff), 12'h000, 0,0,0,0, 0, 0, 0, 0,0, 1, 32'h1c02019c);
      addVec("nop0", 32'h1c0001a4, 32'h00000000, 12'h000, 0,0,0,0, 0, 0, 0, 0,0, 0, 0);
      addVec("nop1", 32'h1c0001a8, 32'hffffffff, 12'h000, 0,0,0,0, 0, 0, 0, 0,0, 0, 0);

      foreach (vecs[i]) begin
         applyStimulus(1'b1, vecs[i].pc, vecs[i].inst);
         cyc();
         applyStimulus(1'b0, 32'd0, 32'd0);
         #1;
         checkOutput({vecs[i].name, ".valid"}, {31'd0, ds_to_es_valid}, 32'd1);
         checkOutput({vecs[i].name, ".pc"}, f_pc, vecs[i].pc);
         checkOutput({vecs[i].name, ".alu_op"}, {20'd0, f_alu_op}, {20'd0, vecs[i].alu_op});
         checkOutput({vecs[i].name, ".ctrl"}, {24'd0, f_ctrl}, {24'd0, vecs[i].ctrl});
         if (vecs[i].chk_src) begin
            checkOutput({vecs[i].name, ".src1"}, f_src1, vecs[i].src1);
            checkOutput({vecs[i].name, ".src2"}, f_src2, vecs[i].src2);
         end
         if (vecs[i].chk_rkd) checkOutput({vecs[i].name, ".rkd"}, f_rkd, vecs[i].rkd);
         checkOutput({vecs[i].name, ".br_taken"}, {31'd0, brbus[32]}, {31'd0, vecs[i].br});
         if (vecs[i].br) checkOutput({vecs[i].name, ".target"}, brbus[31:0], vecs[i].target);
         cyc();
      end

      // taken beq drops the sequential packet offered alongside it
      applyStimulus(1'b1, 32'h1c000010, 32'h58000800);
      cyc();
      applyStimulus(1'b1, 32'h1c000014, r3(17'h20, 3, 1, 2));
      #1;
      checkOutput("drop.br_taken", {31'd0, brbus[32]}, 32'd1);
      checkOutput("drop.target", brbus[31:0], 32'h1c000018);
      checkOutput("drop.ctrl", {24'd0, f_ctrl}, 32'd0);
      cyc();
      applyStimulus(1'b0, 32'd0, 32'd0);
      #1;
      checkOutput("drop.valid_after", {31'd0, ds_to_es_valid}, 32'd0);
      checkOutput("drop.pulse_end", {31'd0, brbus[32]}, 32'd0);
      cyc();

      addHaz("es_rj",     r3(17'h20, 7, 5, 0),         6'h25, 6'h00, 6'h00, 1);
      addHaz("ms_rk",     r3(17'h20, 7, 0, 5),         6'h00, 6'h25, 6'h00, 1);
      addHaz("ws_st_rd",  i12(10'h0a6, 5, 1, 12'h000), 6'h00, 6'h00, 6'h25, 1);
      addHaz("ws_beq_rd", i16(6'h16, 2, 1, 16'h0001),  6'h00, 6'h00, 6'h22, 1);
      addHaz("es_invalid",r3(17'h20, 7, 5, 0),         6'h05, 6'h05, 6'h05, 0);
      addHaz("r0_src",    r3(17'h20, 7, 0, 0),         6'h20, 6'h20, 6'h20, 0);
      addHaz("lu12i_rj",  lu(15, 20'h00005),           6'h25, 6'h00, 6'h00, 0);
      addHaz("b_rj",      b26(6'h14, 26'h0a00000),     6'h25, 6'h00, 6'h00, 0);
      addHaz("slli_rk",   r3(17'h81, 12, 1, 5),        6'h00, 6'h25, 6'h00, 0);
      addHaz("addi_rk",   i12(10'h00a, 6, 1, 12'h005), 6'h25, 6'h00, 6'h00, 0);

      foreach (hazs[i]) begin
         applyStimulus(1'b1, 32'h1c000300, hazs[i].inst);
         cyc();
         applyStimulus(1'b0, 32'd0, 32'd0);
         setDests(hazs[i].es, hazs[i].ms, hazs[i].ws);
         #1;
         checkOutput({hazs[i].name, ".valid"}, {31'd0, ds_to_es_valid}, {31'd0, ~hazs[i].stall});
         checkOutput({hazs[i].name, ".allow_in"}, {31'd0, ds_allow_in}, {31'd0, ~hazs[i].stall});
         setDests(6'd0, 6'd0, 6'd0);
         cyc();
      end

      // RAW on es held for three cycles, then issue the cycle the match clears
      applyStimulus(1'b1, 32'h1c000400, r3(17'h20, 7, 5, 0));
      cyc();
      setDests(6'h25, 6'h00, 6'h00);
      applyStimulus(1'b1, 32'h1c000404, r3(17'h29, 16, 5, 2));
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("raw.valid", {31'd0, ds_to_es_valid}, 32'd0);
         checkOutput("raw.allow_in", {31'd0, ds_allow_in}, 32'd0);
         checkOutput("raw.pc_held", f_pc, 32'h1c000400);
         cyc();
      end
      setDests(6'd0, 6'd0, 6'd0);
      #1;
      checkOutput("raw.release_valid", {31'd0, ds_to_es_valid}, 32'd1);
      checkOutput("raw.release_pc", f_pc, 32'h1c000400);
      cyc();
      applyStimulus(1'b0, 32'd0, 32'd0);
      #1;
      checkOutput("raw.next_pc", f_pc, 32'h1c000404);
      cyc();

      // back-pressure on a taken bne: no pulse until es_allow_in rises
      applyStimulus(1'b1, 32'h1c000200, i16(6'h17, 2, 1, 16'h0004));
      cyc();
      es_allow_in = 1'b0;
      applyStimulus(1'b1, 32'h1c000204, r3(17'h20, 3, 1, 2));
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput("bp.br_taken", {31'd0, brbus[32]}, 32'd0);
         checkOutput("bp.allow_in", {31'd0, ds_allow_in}, 32'd0);
         checkOutput("bp.pc", f_pc, 32'h1c000200);
         checkOutput("bp.src1", f_src1, 32'h00000010);
         cyc();
      end
      es_allow_in = 1'b1;
      #1;
      checkOutput("bp.pulse", {31'd0, brbus[32]}, 32'd1);
      checkOutput("bp.target", brbus[31:0], 32'h1c000210);
      cyc();
      applyStimulus(1'b0, 32'd0, 32'd0);
      #1;
      checkOutput("bp.dropped", {31'd0, ds_to_es_valid}, 32'd0);
      cyc();

      // WB match stalls until the write commits; no bypass of the write data
      applyStimulus(1'b1, 32'h1c000500, 32'h02bffca6);
      cyc();
      applyStimulus(1'b0, 32'd0, 32'd0);
      setDests(6'h00, 6'h00, 6'h25);
      ws_to_rf_bus = {1'b1, 5'd5, 32'hcafebabe};
      #1;
      checkOutput("wb.stall_valid", {31'd0, ds_to_es_valid}, 32'd0);
      checkOutput("wb.no_bypass", f_src1, 32'h12345678);
      cyc();
      setDests(6'd0, 6'd0, 6'd0);
      ws_to_rf_bus = '0;
      #1;
      checkOutput("wb.release_valid", {31'd0, ds_to_es_valid}, 32'd1);
      checkOutput("wb.src1", f_src1, 32'hcafebabe);
      checkOutput("wb.src2", f_src2, 32'hffffffff);
      checkOutput("wb.ctrl", {24'd0, f_ctrl}, 32'h00000026);
      cyc();

      // reset during a stall clears ds_valid but keeps the register file
      applyStimulus(1'b1, 32'h1c000600, r3(17'h20, 7, 5, 0));
      cyc();
      applyStimulus(1'b0, 32'd0, 32'd0);
      setDests(6'h25, 6'h00, 6'h00);
      #1;
      checkOutput("rst.stalled", {31'd0, ds_to_es_valid}, 32'd0);
      reset = 1'b1;
      cyc();
      #1;
      checkOutput("rst.valid", {31'd0, ds_to_es_valid}, 32'd0);
      checkOutput("rst.allow_in", {31'd0, ds_allow_in}, 32'd1);
      reset = 1'b0;
      setDests(6'd0, 6'd0, 6'd0);
      applyStimulus(1'b1, 32'h1c000700, 32'h02bffca6);
      cyc();
      applyStimulus(1'b0, 32'd0, 32'd0);
      #1;
      checkOutput("rst.reload_valid", {31'd0, ds_to_es_valid}, 32'd1);
      checkOutput("rst.rf_kept", f_src1, 32'hcafebabe);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
